seq_divider: RTL

//   Multi-cycle restoring divider: unsigned quotient and remainder of A/B, one quotient bit per clock.

---
 rtl/alu_pkg.sv | 13 +
 rtl/div_step.sv | 28 ++
 rtl/seq_divider.sv | 117 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM state encoding and the divide-by-zero flag position.
package alu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } div_state_t;

   // Bit position of the divide-by-zero flag on the ALU flag bus.
   localparam int DIV_ZERO_FLAG = 3;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract the divisor if it fits.
module div_step #(
   parameter int N = 4
) (
   input  logic [N-1:0] r_i,
   input  logic         dvd_msb_i,
   input  logic [N-1:0] b_i,
   output logic [N-1:0] r_o,
   output logic         q_o
);

   logic [N:0] r_sh;
   logic [N:0] r_sub;

   // r_i is always below the divisor, so the shifted value needs at most N+1 bits.
   assign r_sh  = {r_i, dvd_msb_i};
   assign r_sub = r_sh - {1'b0, b_i};

   always_comb begin
      q_o = 1'b0;
      r_o = r_sh[N-1:0];
      if (r_sh >= {1'b0, b_i}) begin
         q_o = 1'b1;
         r_o = r_sub[N-1:0];
      end
   end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock with a start/done handshake.
//   state | meaning
//   IDLE  | waiting for start; results held
//   RUN   | one quotient bit per edge, N edges
//   FIN   | done pulse for one cycle, then back to IDLE
module seq_divider
   import alu_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_zero
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   div_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  r_q, r_d;
   logic [N-1:0]  dvd_q, dvd_d;
   logic [N-1:0]  b_q, b_d;
   logic [N-1:0]  quo_q, quo_d;
   logic [N-1:0]  rem_q, rem_d;
   logic          dz_q, dz_d;

   logic [N-1:0]  step_r;
   logic          step_q;

   div_step #(.N(N)) u_step (
      .r_i       (r_q),
      .dvd_msb_i (dvd_q[N-1]),
      .b_i       (b_q),
      .r_o       (step_r),
      .q_o       (step_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         r_q     <= '0;
         dvd_q   <= '0;
         b_q     <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         dvd_q   <= dvd_d;
         b_q     <= b_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dz_q    <= dz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      dvd_d   = dvd_q;
      b_d     = b_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dz_d    = dz_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (B != '0) begin
                  dvd_d   = A;
                  b_d     = B;
                  r_d     = '0;
                  cnt_d   = '0;
                  state_d = RUN;
               end else begin
                  quo_d   = '1;
                  rem_d   = A;
                  dz_d    = 1'b1;
                  state_d = FIN;
               end
            end
         end
         RUN: begin
            // Quotient bits enter at the LSB as dividend bits leave at the MSB.
            r_d   = step_r;
            dvd_d = {dvd_q[N-2:0], step_q};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               quo_d   = {dvd_q[N-2:0], step_q};
               rem_d   = step_r;
               dz_d    = 1'b0;
               state_d = FIN;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy      = (state_q == RUN);
   assign done      = (state_q == FIN);
   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign div_zero  = dz_q;

endmodule
